// File: rtl/video_text_term.sv
// Scrolling text terminal: a COLS x ROWS character ring buffer with an
// IDLE/SCROLL/CLEAR write engine and a zero-latency 8x8 glyph video path.
// Optional build macro TERM_CURSOR_EN adds a blinking underline cursor at wptr.

// Glyph source with the CP437 8x8 ROM interface: addr = {char, line}.
// Procedural stand-in patterns; char 0 is always blank so cleared cells show nothing.
module font_cp437_8x8 (
    input  logic [9:0] addr,
    output logic [7:0] data
);
    // Blank for NUL, otherwise a pattern derived from the code and glyph line
    always_comb begin
        data = 8'h00;
        if (addr[9:3] != 7'd0)
            data = {addr[9:3], 1'b1} ^ {5'b0, addr[2:0]};
    end
endmodule

module video_text_term #(
    parameter int COLS       = 32,
    parameter int ROWS       = 32,
    parameter int READY_HPOS = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       te,
    input  logic [6:0] ti,
    output logic       tready,
    output logic       dot
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(COLS);
    localparam logic [AW-1:0] HOME = AW'((ROWS - 1) * COLS);

    typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   wptr, wptr_n, sbase, sbase_n, cnt, cnt_n;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [6:0]      wdata;
    logic [6:0]      mem [DEPTH];

    // State and pointer registers; reset leaves buffer contents alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wptr  <= HOME;
            sbase <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            wptr  <= wptr_n;
            sbase <= sbase_n;
            cnt   <= cnt_n;
        end
    end

    // Command decode in IDLE, one zeroed cell per cycle in SCROLL/CLEAR
    always_comb begin
        state_n = state;
        wptr_n  = wptr;
        sbase_n = sbase;
        cnt_n   = cnt;
        we      = 1'b0;
        waddr   = wptr;
        wdata   = ti;
        unique case (state)
            IDLE: begin
                if (te) begin
                    if (ti >= 7'd32) begin
                        we     = 1'b1;
                        wptr_n = wptr + AW'(1);
                        if (wptr[CW-1:0] == '1) begin
                            state_n = SCROLL;
                            cnt_n   = '0;
                        end
                    end else if (ti == 7'd13) begin
                        wptr_n  = (wptr & ~AW'(COLS - 1)) + AW'(COLS);
                        state_n = SCROLL;
                        cnt_n   = '0;
                    end else if (ti == 7'd8) begin
                        if (wptr[CW-1:0] != '0) begin
                            wptr_n = wptr - AW'(1);
                            we     = 1'b1;
                            waddr  = wptr - AW'(1);
                            wdata  = 7'd0;
                        end
                    end else if (ti == 7'd12) begin
                        state_n = CLEAR;
                        cnt_n   = '0;
                    end
                end
            end
            SCROLL: begin
                we      = 1'b1;
                waddr   = sbase;
                wdata   = 7'd0;
                sbase_n = sbase + AW'(1);
                cnt_n   = cnt + AW'(1);
                if (cnt == AW'(COLS - 1))
                    state_n = IDLE;
            end
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt;
                wdata = 7'd0;
                cnt_n = cnt + AW'(1);
                if (cnt == AW'(DEPTH - 1)) begin
                    state_n = IDLE;
                    wptr_n  = HOME;
                    sbase_n = '0;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Single write port; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (we && !reset)
            mem[waddr] <= wdata;
    end

    assign tready = !reset && (state == IDLE) && !te && (hpos == 9'(READY_HPOS));

    // Video path: screen cell -> ring address -> glyph row -> pixel, all combinational
    logic [4:0]    row;
    logic [5:0]    col;
    logic          in_view;
    logic [AW-1:0] raddr;
    logic [6:0]    chr;
    logic [7:0]    gdata;
    logic          pix;
    logic          unused;

    assign row     = vpos[7:3];
    assign col     = hpos[8:3];
    assign in_view = (7'(col) < 7'(COLS)) && (6'(row) < 6'(ROWS));
    assign raddr   = AW'(row) * AW'(COLS) + AW'(col) + sbase;
    assign chr     = mem[raddr];
    assign pix     = gdata[~hpos[2:0]];
    assign unused  = vpos[8];

    font_cp437_8x8 u_font (
        .addr ({chr, vpos[2:0]}),
        .data (gdata)
    );

`ifdef TERM_CURSOR_EN
    logic [5:0] fcnt;

    // Frame counter advancing at the top-left pixel; bit 5 drives the blink
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fcnt <= '0;
        else if (hpos == 9'd0 && vpos == 9'd0)
            fcnt <= fcnt + 6'd1;
    end

    assign dot = in_view && (pix || (raddr == wptr && vpos[2:0] == 3'd7 && fcnt[5]));
`else
    assign dot = in_view && pix;
`endif
endmodule
